// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan multiplexer.
// Holds the anode polarity, the slot-index width helper and the load FSM states.
// Used by sseg_slot_timer and sseg_scan_mux (optional dimming macro: SSEG_DIM_EN).
package sseg_pkg;

  // Common-anode display: driving an anode high turns the digit off.
  localparam logic SEG_ANODE_OFF = 1'b1;

  // Slot index width; a 2-digit display still needs one bit.
  function automatic int slot_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } load_state_t;

endpackage

// File: rtl/sseg_slot_timer.sv
// Purpose: prescaler + slot counter that paces the digit scan; flags the last cycle of a frame.
// Latency: combinational frame_end from the current counter state; counters advance every clk.
// Backpressure: none, free-running once out of reset.
// Ports: clk, rst_n (sync, active-low) in; prescaler, slot, frame_end out.
module sseg_slot_timer #(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_CYCLES = 100000,
  parameter int SW          = 3,
  parameter int PW          = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [PW-1:0] prescaler,
  output logic [SW-1:0] slot,
  output logic          frame_end
);

  logic slot_end;
  logic last_slot;

  assign slot_end  = (prescaler == PW'(SLOT_CYCLES - 1));
  assign last_slot = (slot == SW'(NUM_DIGITS - 1));
  assign frame_end = slot_end && last_slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      slot      <= '0;
    end else if (slot_end) begin
      prescaler <= '0;
      // Explicit wrap: NUM_DIGITS need not be a power of two.
      slot      <= last_slot ? '0 : slot + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Purpose: time-multiplexed scan of an N-digit common-anode display with a double-buffered frame.
// Latency: all display outputs are registered, one cycle behind the slot counter.
// Backpressure: ready low while a frame is pending; it commits on the next frame_tick.
// Ports: clk, rst_n, load, digits_in, dp_in, blank_in [, brightness] in;
//        ready, anode_n, digitOn, dp_n, slot_idx, frame_tick out.
// Optional: define SSEG_DIM_EN to add the 4-bit brightness PWM input.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_W      = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
`ifdef SSEG_DIM_EN
  input  logic [3:0]                      brightness,
`endif
  input  logic                            load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic [NUM_DIGITS-1:0]           blank_in,
  output logic                            ready,
  output logic [NUM_DIGITS-1:0]           anode_n,
  output logic [DIGIT_W-1:0]              digitOn,
  output logic                            dp_n,
  output logic [slot_w(NUM_DIGITS)-1:0]   slot_idx,
  output logic                            frame_tick
);

  localparam int SW = slot_w(NUM_DIGITS);
  localparam int PW = $clog2(SLOT_CYCLES);

  logic [PW-1:0] prescaler;
  logic [SW-1:0] slot;
  logic          frame_end;

  sseg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .SW          (SW),
    .PW          (PW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .prescaler (prescaler),
    .slot      (slot),
    .frame_end (frame_end)
  );

  // Load FSM: one pending frame at most; commit lands on the frame boundary.
  load_state_t state, state_nxt;
  logic        capture;
  logic        commit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A load coinciding with frame_end in IDLE is only captured; the commit
  // waits for the next frame_end so a frame is never shown half-written.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  // Pending and display buffers.
  logic [DIGIT_W-1:0]    pend_digit [NUM_DIGITS];
  logic [DIGIT_W-1:0]    disp_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        pend_digit[k] <= '0;
        disp_digit[k] <= '0;
      end
      pend_dp    <= '0;
      pend_blank <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;  // dark until the first frame is committed
    end else begin
      if (capture) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          pend_digit[k] <= digits_in[k*DIGIT_W +: DIGIT_W];
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
      end
      if (commit) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          disp_digit[k] <= pend_digit[k];
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
    end
  end

  // Anti-ghosting window: anodes stay off for the first BLANK_CYCLES of a slot.
  logic in_window;
  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign in_window = 1'b1;
    end else begin : g_gap
      assign in_window = (prescaler >= PW'(BLANK_CYCLES));
    end
  endgenerate

  logic duty_on;
`ifdef SSEG_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Strict compare: brightness 0 is dark, 15 gives 15/16 duty.
  assign duty_on = (pwm_cnt < brightness);
`else
  assign duty_on = 1'b1;
`endif

  // Registered outputs; digit code and dp follow the slot even while blanked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode_n    <= {NUM_DIGITS{SEG_ANODE_OFF}};
      digitOn    <= '0;
      dp_n       <= 1'b1;
      slot_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      anode_n <= {NUM_DIGITS{SEG_ANODE_OFF}};
      if (in_window && duty_on && !disp_blank[slot])
        anode_n[slot] <= ~SEG_ANODE_OFF;
      digitOn    <= disp_digit[slot];
      dp_n       <= ~disp_dp[slot];
      slot_idx   <= slot;
      frame_tick <= frame_end;
    end
  end

endmodule
